layer_done_notifier: RTL and testbench
======================================

Name: layer_done_notifier

Overview:
- Upstream neighbour of the interrupt register. Counts output-word writes from the single-layer CNN engine for one layer run.
- After the last expected write, waits a fixed pipeline-drain interval, then emits a one-cycle write (write_signal=1, write_data=1) that sets the sticky interrupt bit.
- Holds off further runs until the CPU acknowledges, and flags protocol errors.

Parameters:
- CNT_W, 16, width of total_words and words_done; a layer run covers at most 2^CNT_W-1 words.
- DRAIN_CYCLES, 4, cycles waited after the last out_valid before notifying (0 allowed); range 0..255.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that loads total_words and begins a run; honoured only in IDLE.
- total_words  input  CNT_W  number of output words expected this run; sampled on accepted start.
- out_valid  input  1  engine output-write strobe; one word per asserted cycle.
- irq_ack  input  1  CPU acknowledge; returns the FSM from WAIT_ACK to IDLE.
- busy  output  1  high in every state except IDLE.
- words_done  output  CNT_W  words counted in the current or last run.
- write_signal  output  1  one-cycle write strobe to the interrupt register.
- write_data  output  1  data to the interrupt register; equals write_signal.
- err  output  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high. All state changes on the rising edge of clk.
- Reset: rst sampled high forces state=IDLE and clears busy, words_done, write_signal, write_data, err, the internal target and the drain counter. rst overrides every other input in the same cycle.
- Reset mid-run: a run in progress is abandoned and no write pulse is produced.
- FSM states: IDLE, COUNT, DRAIN, NOTIFY, WAIT_ACK.
- IDLE, start=1:
  - Capture target=total_words, clear words_done, clear err.
  - If total_words!=0, go to COUNT.
  - If total_words==0 and DRAIN_CYCLES>0, go to DRAIN with drain_cnt=DRAIN_CYCLES-1.
  - If total_words==0 and DRAIN_CYCLES==0, go to NOTIFY.
  - out_valid in the same cycle as an accepted start is not counted and sets err. Setting err takes priority over the start-clear.
- IDLE, start=0: out_valid=1 sets err; words_done is unchanged.
- COUNT:
  - Each out_valid=1 cycle increments words_done by 1.
  - If out_valid=1 and words_done==target-1, the increment still happens and the FSM leaves COUNT:
    - DRAIN_CYCLES>0: go to DRAIN with drain_cnt=DRAIN_CYCLES-1.
    - DRAIN_CYCLES==0: go to NOTIFY.
  - No timeout; COUNT waits indefinitely.
- DRAIN:
  - drain_cnt decrements each cycle.
  - When drain_cnt==0, go to NOTIFY.
  - out_valid=1 here sets err and is not counted.
- NOTIFY:
  - Lasts exactly one cycle with write_signal=1 and write_data=1, then go to WAIT_ACK.
  - out_valid=1 here sets err.
- WAIT_ACK:
  - irq_ack=1 returns the FSM to IDLE; busy drops on the next cycle.
  - out_valid=1 sets err.
  - irq_ack=1 in any other state is ignored.
- start outside IDLE: ignored, sets err, and does not reload target or words_done.
- Latency: if the last out_valid is sampled at edge k, write_signal is high for exactly the one cycle following edge k+DRAIN_CYCLES. For a zero-word run, the same rule applies with k = the edge that sampled start.
- Outputs outside NOTIFY: write_signal=0 and write_data=0 in every other state; both are registered outputs.
- words_done: holds its final value through DRAIN, NOTIFY, WAIT_ACK and IDLE until the next accepted start.
- Counter width: words_done never wraps, because counting stops at target ≤ 2^CNT_W-1.

Test Plan:
- Basic run: rst 2 cycles; start with total_words=8; 8 consecutive out_valid; DRAIN_CYCLES=4 -> words_done=8, write_signal=write_data=1 for exactly 1 cycle, 4 cycles after the last valid edge; busy stays 1 until irq_ack, then 0.
- Gapped strobes: total_words=5, out_valid on cycles 1,3,4,9,12 -> pulse follows the cycle-12 edge by 4 cycles; no pulse earlier; err=0.
- Zero-length run: start with total_words=0 -> no COUNT state; pulse 4 cycles after the start edge; words_done=0.
- Protocol errors:
  - out_valid in IDLE -> err=1.
  - Second start during COUNT -> err=1, and target stays at the original value (pulse after the original word count).
  - Extra out_valid in DRAIN -> err=1, words_done unchanged.
- Reset mid-run: start with total_words=10, 6 valids, then rst for 1 cycle -> IDLE, all outputs 0, no write_signal pulse afterwards.
- Back-to-back runs: run 1 with 3 words; irq_ack; start with 4 words in the cycle after busy=0 -> two separate single-cycle pulses; err cleared at the second start; words_done=4 after run 2.

Source files
------------

// File: rtl/layer_done_notifier.sv
// Counts CNN output-word writes for one layer run, waits a fixed drain interval after the last
// word, then pulses a one-cycle write that sets the sticky interrupt bit. Flags protocol errors.
module layer_done_notifier #(
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] total_words,
  input  logic             out_valid,
  input  logic             irq_ack,
  output logic             busy,
  output logic [CNT_W-1:0] words_done,
  output logic             write_signal,
  output logic             write_data,
  output logic             err
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCount   = 3'd1;
  localparam logic [2:0] StDrain   = 3'd2;
  localparam logic [2:0] StNotify  = 3'd3;
  localparam logic [2:0] StWaitAck = 3'd4;

  // Drain counter is loaded with DRAIN_CYCLES-1 so NOTIFY follows the last word by DRAIN_CYCLES.
  localparam logic [7:0] DrainLoad = (DRAIN_CYCLES == 0) ? 8'd0 : 8'(DRAIN_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic [CNT_W-1:0] words_inc;
  logic [7:0]       drain_q, drain_d;
  logic             err_q, err_d;
  logic             write_q, write_d;

  assign words_inc = words_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    words_d  = words_q;
    drain_d  = drain_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          target_d = total_words;
          words_d  = '0;
          err_d    = 1'b0;
          if (total_words != '0) begin
            state_d = StCount;
          end else if (DRAIN_CYCLES > 0) begin
            state_d = StDrain;
            drain_d = DrainLoad;
          end else begin
            state_d = StNotify;
          end
        end
      end
      StCount: begin
        if (out_valid) begin
          words_d = words_inc;
          if (words_inc == target_q) begin
            if (DRAIN_CYCLES > 0) begin
              state_d = StDrain;
              drain_d = DrainLoad;
            end else begin
              state_d = StNotify;
            end
          end
        end
      end
      StDrain: begin
        if (drain_q == 8'd0) begin
          state_d = StNotify;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      StNotify: begin
        state_d = StWaitAck;
      end
      StWaitAck: begin
        if (irq_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Error sets come last so they win over the clear on an accepted start.
    if (out_valid && (state_q != StCount)) begin
      err_d = 1'b1;
    end
    if (start && (state_q != StIdle)) begin
      err_d = 1'b1;
    end

    write_d = (state_d == StNotify);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      target_q <= '0;
      words_q  <= '0;
      drain_q  <= 8'd0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      words_q  <= words_d;
      drain_q  <= drain_d;
      err_q    <= err_d;
      write_q  <= write_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign words_done   = words_q;
  assign write_signal = write_q;
  assign write_data   = write_q;
  assign err          = err_q;

endmodule

// File: tb/tb_layer_done_notifier.sv
// Self-checking bench for layer_done_notifier: directed scenarios plus random traffic, all
// compared against an edge-scheduled reference model.
module tb_layer_done_notifier;

  localparam int unsigned CNT_W = 16;
  localparam int          D     = 4;

  logic             clk = 1'b0;
  logic             rst, start, out_valid, irq_ack;
  logic [CNT_W-1:0] total_words;
  logic             busy, write_signal, write_data, err;
  logic [CNT_W-1:0] words_done;

  layer_done_notifier #(
    .CNT_W       (CNT_W),
    .DRAIN_CYCLES(D)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .total_words (total_words),
    .out_valid   (out_valid),
    .irq_ack     (irq_ack),
    .busy        (busy),
    .words_done  (words_done),
    .write_signal(write_signal),
    .write_data  (write_data),
    .err         (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;

  // Reference model: a run is active from accepted start until ack; the pulse is scheduled at an
  // absolute edge number once the last word (or a zero-word start) is seen.
  int          e = 0;
  bit          m_active = 1'b0;
  int          m_p = -1;
  int unsigned m_target = 0, m_words = 0;
  bit          m_err = 1'b0, m_write = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, e);
    end
  endtask

  task automatic model(input bit r, input bit s, input int unsigned tw, input bit ov,
                       input bit ack);
    bit idle, counting, waiting;
    e++;
    if (r) begin
      m_active = 1'b0; m_p = -1; m_words = 0; m_target = 0; m_err = 1'b0; m_write = 1'b0;
      return;
    end
    idle     = !m_active;
    counting = m_active && (m_p < 0);
    waiting  = m_active && (m_p >= 0) && (e >= m_p + 2);
    if (idle && s) begin
      m_target = tw; m_words = 0; m_err = 1'b0; m_active = 1'b1;
      m_p = (tw == 0) ? e + D : -1;
    end else if (s) begin
      m_err = 1'b1;
    end
    if (ov) begin
      if (counting) begin
        m_words++;
        if (m_words == m_target) m_p = e + D;
      end else begin
        m_err = 1'b1;
      end
    end
    if (waiting && ack) begin
      m_active = 1'b0;
      m_p = -1;
    end
    m_write = m_active && (m_p == e);
  endtask

  task automatic step(input bit r, input bit s, input int unsigned tw, input bit ov, input bit ack);
    rst = r; start = s; total_words = tw[CNT_W-1:0]; out_valid = ov; irq_ack = ack;
    @(posedge clk);
    model(r, s, tw, ov, ack);
    #1;
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("words_done", 32'(words_done), m_words);
    check_eq("write_signal", 32'(write_signal), 32'(m_write));
    check_eq("write_data", 32'(write_data), 32'(m_write));
    check_eq("err", 32'(err), 32'(m_err));
    if (write_signal === 1'b1) pulses++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    int sched[5];
    bit r, s, ov, ack;
    int unsigned tw;

    // Basic run
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    pulses = 0;
    step(1'b0, 1'b1, 8, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle_n(8);
    check_eq("basic_pulses", pulses, 1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    idle_n(2);

    // Gapped strobes
    sched = '{1, 3, 4, 9, 12};
    pulses = 0;
    step(1'b0, 1'b1, 5, 1'b0, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      ov = 1'b0;
      foreach (sched[j]) if (sched[j] == c) ov = 1'b1;
      step(1'b0, 1'b0, 0, ov, 1'b0);
    end
    check_eq("gap_early_pulse", pulses, 0);
    idle_n(6);
    check_eq("gap_pulses", pulses, 1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Zero-length run
    pulses = 0;
    step(1'b0, 1'b1, 0, 1'b0, 1'b0);
    idle_n(6);
    check_eq("zero_pulses", pulses, 1);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Protocol errors: stray valid in idle, restart during count, extra valid in drain
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle_n(6);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Reset mid-run
    step(1'b0, 1'b1, 10, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    pulses = 0;
    step(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle_n(20);
    check_eq("reset_no_pulse", pulses, 0);

    // Back-to-back runs
    pulses = 0;
    step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 3, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle_n(6);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 1'b1, 1'b0);
    idle_n(6);
    check_eq("b2b_pulses", pulses, 2);
    step(1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 299) == 0);
      s   = m_active ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 3) == 0);
      tw  = $urandom_range(0, 9);
      ov  = (m_active && m_p < 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
      ack = ($urandom_range(0, 2) == 0);
      step(r, s, tw, ov, ack);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
